// File: rtl/tc7_to_binary.sv
// tc7_to_binary: two-stage valid/ready decoder from 6-bit mod-7 thermometer code to a binary residue.
// Define TC7_BUBBLE_CORRECT_EN to decode bubble codes to their saturated popcount instead of 0.
module tc7_to_binary (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] in_tc,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_res,
  output logic       out_err,
  input  logic       err_clr,
  output logic [7:0] err_cnt
);
  logic       s1_valid, s1_legal, s2_adv, in_legal;
  logic [5:0] s1_tc;
  logic [2:0] in_pc, s1_pc, res_d;
  function automatic logic [2:0] popcnt(input logic [5:0] v);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < 6; i++) c = c + 3'(v[i]);
    return c;
  endfunction
  assign s2_adv   = !out_valid | out_ready;
  assign in_ready = !s1_valid | s2_adv;
  assign in_pc    = popcnt(in_tc);
  assign in_legal = in_tc == 6'((7'd1 << in_pc) - 7'd1);
  assign s1_pc    = popcnt(s1_tc);
  always_comb begin
`ifdef TC7_BUBBLE_CORRECT_EN
    res_d = s1_legal ? s1_pc : (s1_pc > 3'd6 ? 3'd6 : s1_pc);
`else
    res_d = s1_legal ? s1_pc : 3'd0;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_tc     <= '0;
      s1_legal  <= 1'b0;
      out_valid <= 1'b0;
      out_res   <= '0;
      out_err   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_valid & in_ready) begin
        s1_tc    <= in_tc;
        s1_legal <= in_legal;
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_res <= res_d;
          out_err <= !s1_legal;
        end
      end
      // clear has priority over a coincident erroring transfer
      err_cnt <= err_clr ? 8'd0 :
                 (out_valid & out_ready & out_err & (err_cnt != 8'hff)) ? err_cnt + 8'd1 : err_cnt;
    end
  end
endmodule

// File: doc/tc7_to_binary.md
# tc7_to_binary

Streaming decoder from 6-bit thermometer code back to a 3-bit mod-7 residue. It is the inverse of the binary-to-thermometer (mod 7) front end in the RNS modulo adder datapath. It sits after the thermometer-domain adder/rotator and returns residues to binary for output and reconversion. It adds a two-stage valid/ready pipeline, bubble (invalid-code) detection and a saturating error counter.

## Interface
- No parameters; the modulus is fixed at 7 and the code width at 6.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_tc holds a code to transfer.
- in_ready  output  1  the block accepts in_tc this cycle.
- in_tc  input  6  thermometer code; bit 0 is the LSB (the first bit to fill).
- out_valid  output  1  out_res/out_err are valid.
- out_ready  input  1  downstream accepts this cycle.
- out_res  output  3  decoded residue, 0..6.
- out_err  output  1  the accepted code was not a legal thermometer code.
- err_clr  input  1  synchronous clear of err_cnt.
- err_cnt  output  8  saturating count of delivered words with out_err=1.

## Operation
- Legal codes are exactly the 7 values 000000, 000001, 000011, 000111, 001111, 011111 and 111111. They decode to 0..6 respectively.
- Any other of the 64 values is a bubble code and produces out_err=1. Residue on a bubble code:
  - Macro undefined: out_res=0.
  - Macro defined: see Configuration.
- Stage 1 (S1) registers in_tc on a transfer (in_valid & in_ready). It also registers a legality flag computed as: in_tc equals ((1<<popcount)-1).
- Stage 2 (S2) registers out_res and out_err from S1 and drives the outputs directly from flops.
- Each stage has a valid bit. A stage advances when the next stage is empty or is draining this cycle.
  - S2 drains on out_valid & out_ready.
  - in_ready = !s1_valid | !s2_valid | out_ready. This is combinational from out_ready only; there is no combinational path from in_valid to in_ready.
- Data in a stalled stage holds unchanged. out_res, out_err and out_valid stay stable while out_valid=1 and out_ready=0.
- err_cnt increments by 1 on each output transfer with out_err=1. It saturates at 255.
- err_clr=1 sets err_cnt to 0 on the next edge. If err_clr coincides with an erroring transfer, clear wins and the result is 0.

## Timing
- Reset (rst_n=0, asynchronous) forces s1_valid=0, s2_valid=0, out_valid=0, out_res=0, out_err=0 and err_cnt=0.
  - in_ready reads 1 during reset, but no transfer occurs while rst_n=0.
- Reset mid-operation discards all in-flight words. No partial word is ever emitted.
- Latency: a word accepted at edge N gives out_valid=1 after edge N+1, assuming no stall.
- Throughput: 1 word/cycle with out_ready held high.
- Full condition: both stages valid and out_ready=0 gives in_ready=0. At most 2 words are buffered.
- Empty condition: out_valid=0. out_res/out_err hold their last value and are don't-care for checking.
- Simultaneous accept and drain with both stages full is a legal transfer. No word is lost or duplicated.

## Configuration
- Macro TC7_BUBBLE_CORRECT_EN.
- Defined: a bubble code decodes to out_res = popcount(in_tc) if that count is ≤6, and saturates at 6. out_err is still 1 and still counted.
- Undefined: a bubble code decodes to out_res=0 and out_err=1.
- Legal-code behaviour is identical in both builds.

## Test plan
- Reset release with out_ready=1, then stream all 7 legal codes back-to-back.
  - Required: out_res = 0,1,2,3,4,5,6 in order, the first after 2 edges, one per cycle.
  - out_err=0 throughout and err_cnt=0.
- Send in_tc=000101, then 100000.
  - Macro undefined: out_res=0 for both.
  - Macro defined: out_res=2 for 000101 and 1 for 100000.
  - Both builds: out_err=1 for both and err_cnt=2.
- Hold out_ready=0 and offer 3 words (000111, 001111, 011111).
  - Required: in_ready drops after 2 accepts.
  - out_res=3 held stable.
  - After out_ready=1, outputs are 3, 4, 5 with no loss.
- Stream 300 bubble words (010101).
  - Required: err_cnt saturates at 255.
  - Pulse err_clr together with a bubble transfer: err_cnt=0 on the next edge.
- Assert rst_n=0 asynchronously mid-stream with 2 words buffered.
  - Required: out_valid=0 immediately and err_cnt=0.
  - After release, the first output is the first word sent after reset.
- Randomised in_valid/out_ready toggling over 1000 legal codes.
  - Required: output sequence equals input sequence, with out_err never set.
